// File: rtl/branch_predictor_btb_pkg.sv
// Shared types and helpers for the branch target buffer and its counters.
package branch_predictor_btb_pkg;

    typedef enum logic [1:0] {
        BP_OFF     = 2'd0,
        BP_HIT     = 2'd1,
        BP_BIMODAL = 2'd2
    } bp_mode_e;

    localparam int unsigned BTB_XLEN  = 32;
    localparam int unsigned BTB_IDX_W = 4;
    localparam int unsigned BTB_TAG_W = BTB_XLEN - BTB_IDX_W - 1;
    localparam int unsigned BTB_CNT_W = 2;

    // Entry layout at the default geometry; the top keeps the fields in separate arrays.
    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_XLEN-1:0]  target;
        logic [BTB_CNT_W-1:0] cnt;
    } btb_entry_t;

    function automatic logic [63:0] sat_step(input logic [63:0] val,
                                             input logic [63:0] max_val,
                                             input logic        inc,
                                             input logic        dec);
        if (inc && !dec) begin
            return (val == max_val) ? val : val + 64'd1;
        end else if (dec && !inc) begin
            return (val == 64'd0) ? val : val - 64'd1;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter with clear and load; clear beats load beats inc/dec.
module branch_predictor_btb_sat_counter
    import branch_predictor_btb_pkg::*;
#(
    parameter int unsigned W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o
);

    localparam logic [63:0] MAX_V = (64'd1 << W) - 64'd1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else begin
            cnt_d = W'(sat_step(64'(cnt_q), MAX_V, inc_i, dec_i));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry direction counters, selectable prediction
// mode, bulk flush and saturating lookup/mispredict statistics.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned MODE    = 2,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_valid_i,
    input  logic [XLEN-1:0]   fetch_pc_i,
    output logic              fetch_hit_o,
    output logic              fetch_taken_o,
    output logic [XLEN-1:0]   fetch_target_o,
    input  logic              ex_valid_i,
    input  logic              ex_is_branch_i,
    input  logic              ex_taken_i,
    input  logic [XLEN-1:0]   ex_pc_i,
    input  logic [XLEN-1:0]   ex_target_i,
    input  logic              ex_mispredict_i,
    input  logic              flush_i,
    input  logic              stat_clear_i,
    output logic [STAT_W-1:0] stat_lookups_o,
    output logic [STAT_W-1:0] stat_mispred_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 1;
    localparam logic [1:0]  MODE_L = MODE[1:0];
    localparam bit          PRED_ON = (MODE_L == BP_HIT) || (MODE_L == BP_BIMODAL);
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(32'd1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

    logic [IDX_W-1:0]  f_idx_s, u_idx_s;
    logic [TAG_W-1:0]  f_tag_s, u_tag_s;
    logic              f_match_s, u_hit_s, upd_en_s, alloc_s;
    logic              fetch_hit_s, fetch_taken_s;
    logic              unused_pc_lsb_s;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_s    [ENTRIES];

    // Halfword-aligned addressing: bit 0 never takes part in index or tag.
    assign f_idx_s         = fetch_pc_i[IDX_W:1];
    assign f_tag_s         = fetch_pc_i[XLEN-1:IDX_W+1];
    assign u_idx_s         = ex_pc_i[IDX_W:1];
    assign u_tag_s         = ex_pc_i[XLEN-1:IDX_W+1];
    assign unused_pc_lsb_s = fetch_pc_i[0] ^ ex_pc_i[0];

    assign f_match_s = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
    assign u_hit_s   = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);
    assign upd_en_s  = ex_valid_i && ex_is_branch_i && PRED_ON && !flush_i;
    assign alloc_s   = upd_en_s && !u_hit_s && ex_taken_i;

    always_comb begin
        fetch_hit_s   = 1'b0;
        fetch_taken_s = 1'b0;
        case (MODE_L)
            BP_HIT: begin
                fetch_hit_s   = f_match_s;
                fetch_taken_s = f_match_s;
            end
            BP_BIMODAL: begin
                fetch_hit_s   = f_match_s;
                fetch_taken_s = f_match_s && cnt_s[f_idx_s][CNT_W-1];
            end
            default: begin
                fetch_hit_s   = 1'b0;
                fetch_taken_s = 1'b0;
            end
        endcase
    end

    assign fetch_hit_o    = fetch_hit_s;
    assign fetch_taken_o  = fetch_taken_s;
    assign fetch_target_o = fetch_hit_s ? target_q[f_idx_s] : '0;

    // A taken update writes valid/tag/target whether it hits or allocates;
    // on a hit the tag and valid bit are rewritten with the values they already hold.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (upd_en_s && ex_taken_i) begin
            valid_d[u_idx_s]  = 1'b1;
            tag_d[u_idx_s]    = u_tag_s;
            target_d[u_idx_s] = ex_target_i;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
        logic sel_s;
        assign sel_s = (u_idx_s == IDX_W'(i));
        branch_predictor_btb_sat_counter #(.W(CNT_W), .RST_VAL(CNT_WEAK_NT)) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clear_i    (1'b0),
            .load_i     (alloc_s && sel_s),
            .load_val_i (CNT_WEAK_T),
            .inc_i      (upd_en_s && u_hit_s && sel_s && ex_taken_i),
            .dec_i      (upd_en_s && u_hit_s && sel_s && !ex_taken_i),
            .count_o    (cnt_s[i])
        );
    end

    branch_predictor_btb_sat_counter #(.W(STAT_W), .RST_VAL('0)) u_stat_lookups (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (stat_clear_i),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (fetch_valid_i),
        .dec_i      (1'b0),
        .count_o    (stat_lookups_o)
    );

    branch_predictor_btb_sat_counter #(.W(STAT_W), .RST_VAL('0)) u_stat_mispred (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (stat_clear_i),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (ex_valid_i && ex_mispredict_i),
        .dec_i      (1'b0),
        .count_o    (stat_mispred_o)
    );

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench: three BTB instances (MODE 0/1/2) share stimulus; each
// expectation names the instance it checks.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_valid, ex_valid, ex_is_branch, ex_taken, ex_mispredict;
    logic        flush, stat_clear;
    logic [31:0] fetch_pc, ex_pc, ex_target;

    logic        hit_o   [3];
    logic        taken_o [3];
    logic [31:0] tgt_o   [3];
    logic [3:0]  lk_o    [3];
    logic [3:0]  mp_o    [3];

    typedef struct {
        string       name;
        int          sel;
        bit          chk_p;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
        bit          chk_s;
        logic [3:0]  el;
        logic [3:0]  em;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        branch_predictor_btb #(
            .XLEN(32), .ENTRIES(16), .CNT_W(2), .MODE(m), .STAT_W(4)
        ) u_dut (
            .clk_i           (clk),
            .rst_i           (rst),
            .fetch_valid_i   (fetch_valid),
            .fetch_pc_i      (fetch_pc),
            .fetch_hit_o     (hit_o[m]),
            .fetch_taken_o   (taken_o[m]),
            .fetch_target_o  (tgt_o[m]),
            .ex_valid_i      (ex_valid),
            .ex_is_branch_i  (ex_is_branch),
            .ex_taken_i      (ex_taken),
            .ex_pc_i         (ex_pc),
            .ex_target_i     (ex_target),
            .ex_mispredict_i (ex_mispredict),
            .flush_i         (flush),
            .stat_clear_i    (stat_clear),
            .stat_lookups_o  (lk_o[m]),
            .stat_mispred_o  (mp_o[m])
        );
    end

    task automatic clr_in();
        fetch_valid = 1'b0; fetch_pc = 32'h0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0;
        ex_pc = 32'h0; ex_target = 32'h0; ex_mispredict = 1'b0;
        flush = 1'b0; stat_clear = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    task automatic push(input string nm, input int sel, input logic [31:0] pc,
                        input bit cp, input logic eh, input logic et, input logic [31:0] etgt,
                        input bit cs, input logic [3:0] el, input logic [3:0] em);
        exp_t e;
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        e.name = nm; e.sel = sel; e.chk_p = cp; e.eh = eh; e.et = et; e.etgt = etgt;
        e.chk_s = cs; e.el = el; e.em = em;
        q.push_back(e);
    endtask

    task automatic look(input string nm, input int sel, input logic [31:0] pc,
                        input logic eh, input logic et, input logic [31:0] etgt);
        push(nm, sel, pc, 1'b1, eh, et, etgt, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = tk;
        ex_pc = pc; ex_target = tgt; ex_mispredict = mp;
    endtask

    // Reset with a pending taken update at 0x10C that must be discarded.
    task automatic do_reset(input int sel);
        rst = 1'b1;
        upd(32'h10C, 1'b1, 32'h900, 1'b0);
        push("reset_outputs", sel, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd0);
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (fetch_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL underrun: lookup at pc=%h with no expectation queued", fetch_pc);
            end else begin
                e = q.pop_front();
                if (e.chk_p) begin
                    checks++;
                    if ({hit_o[e.sel], taken_o[e.sel], tgt_o[e.sel]} !== {e.eh, e.et, e.etgt}) begin
                        errors++;
                        $display("FAIL %s (mode %0d): got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                                 e.name, e.sel, hit_o[e.sel], taken_o[e.sel], tgt_o[e.sel], e.eh, e.et, e.etgt);
                    end
                end
                if (e.chk_s) begin
                    checks++;
                    if ({lk_o[e.sel], mp_o[e.sel]} !== {e.el, e.em}) begin
                        errors++;
                        $display("FAIL %s stats (mode %0d): got lookups=%0d mispred=%0d, want lookups=%0d mispred=%0d",
                                 e.name, e.sel, lk_o[e.sel], mp_o[e.sel], e.el, e.em);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        clr_in();
        repeat (2) @(posedge clk);
        #1;

        // Bimodal: allocate, train down, saturate up, alias, bypass, flush.
        do_reset(2);
        look("cold_miss", 2, 32'h100, 1'b0, 1'b0, 32'h0); tick();
        upd(32'h100, 1'b1, 32'h200, 1'b0); tick();
        look("alloc_hit", 2, 32'h100, 1'b1, 1'b1, 32'h200); tick();
        upd(32'h100, 1'b0, 32'h0, 1'b0); tick();
        upd(32'h100, 1'b0, 32'h0, 1'b0); tick();
        look("trained_nt", 2, 32'h100, 1'b1, 1'b0, 32'h200); tick();
        for (int i = 0; i < 4; i++) begin
            upd(32'h100, 1'b1, 32'h200, 1'b0); tick();
        end
        look("sat_taken", 2, 32'h100, 1'b1, 1'b1, 32'h200); tick();
        upd(32'h100, 1'b0, 32'h0, 1'b0); tick();
        look("no_wrap", 2, 32'h100, 1'b1, 1'b1, 32'h200); tick();
        look("alias_miss", 2, 32'h120, 1'b0, 1'b0, 32'h0); tick();
        upd(32'h120, 1'b1, 32'h300, 1'b0); tick();
        look("evicted", 2, 32'h100, 1'b0, 1'b0, 32'h0); tick();
        look("alias_hit", 2, 32'h120, 1'b1, 1'b1, 32'h300); tick();
        upd(32'h140, 1'b0, 32'h0, 1'b0); tick();
        look("nt_miss_keep", 2, 32'h120, 1'b1, 1'b1, 32'h300); tick();
        look("nt_miss_noalloc", 2, 32'h140, 1'b0, 1'b0, 32'h0); tick();
        upd(32'h120, 1'b1, 32'h500, 1'b0);
        look("same_cycle_old", 2, 32'h120, 1'b1, 1'b1, 32'h300); tick();
        look("same_cycle_new", 2, 32'h120, 1'b1, 1'b1, 32'h500); tick();
        upd(32'h104, 1'b1, 32'h600, 1'b0); tick();
        look("idx2_hit", 2, 32'h104, 1'b1, 1'b1, 32'h600); tick();
        flush = 1'b1;
        upd(32'h108, 1'b1, 32'h700, 1'b0); tick();
        look("flush_idx0", 2, 32'h120, 1'b0, 1'b0, 32'h0); tick();
        look("flush_idx2", 2, 32'h104, 1'b0, 1'b0, 32'h0); tick();
        look("flush_beats_upd", 2, 32'h108, 1'b0, 1'b0, 32'h0); tick();

        // Statistics saturation and clear priority.
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            if (i < 3) begin
                ex_valid = 1'b1; ex_mispredict = 1'b1;
            end
            push("stat_count", 2, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1,
                 4'((i > 15) ? 15 : i), 4'((i > 3) ? 3 : i));
            tick();
        end
        stat_clear = 1'b1;
        push("stat_pre_clear", 2, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd15, 4'd3); tick();
        push("stat_cleared", 2, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd0); tick();
        push("reset_drops_upd", 2, 32'h10C, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'd1, 4'd0); tick();

        // Hit-means-taken ignores the counter.
        do_reset(1);
        upd(32'h100, 1'b1, 32'h200, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            upd(32'h100, 1'b0, 32'h0, 1'b0); tick();
        end
        look("mode1_taken", 1, 32'h100, 1'b1, 1'b1, 32'h200); tick();
        look("mode2_same_nt", 2, 32'h100, 1'b1, 1'b0, 32'h200); tick();

        // Predictor off: no hits, statistics still run.
        do_reset(0);
        upd(32'h100, 1'b1, 32'h200, 1'b1); tick();
        push("mode0_off", 0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd1); tick();
        look("mode2_ref", 2, 32'h100, 1'b1, 1'b1, 32'h200); tick();

        tick();
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised successor to the single-mode branch predictor in the pipelined core.
- A direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Three selectable modes: off, hit-means-taken and bimodal.
- Provides a bulk flush and saturating performance counters.
- Sits beside fetch: the combinational lookup serves the fetch PC, and resolved-branch updates arrive from execute.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, number of BTB entries; power of two, >=2. IDX_W = log2(ENTRIES).
- CNT_W, 2, direction counter width, >=1.
- MODE, 2, 0 = predictor off, 1 = hit implies taken, 2 = bimodal (taken when counter MSB = 1).
- STAT_W, 32, performance counter width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- fetch_valid_i  in  1  a lookup is being made this cycle (used for statistics only).
- fetch_pc_i  in  XLEN  PC being fetched.
- fetch_hit_o  out  1  valid entry whose tag matches.
- fetch_taken_o  out  1  predict taken.
- fetch_target_o  out  XLEN  predicted target.
- ex_valid_i  in  1  resolved control-flow instruction in execute.
- ex_is_branch_i  in  1  instruction is a branch or jump.
- ex_taken_i  in  1  resolved direction.
- ex_pc_i  in  XLEN  PC of the resolved instruction.
- ex_target_i  in  XLEN  resolved target.
- ex_mispredict_i  in  1  fetch prediction was wrong.
- flush_i  in  1  invalidate all entries.
- stat_clear_i  in  1  zero the performance counters.
- stat_lookups_o  out  STAT_W  count of fetch_valid_i cycles.
- stat_mispred_o  out  STAT_W  count of mispredictions.

Behaviour:
- Addressing (halfword aligned, so compressed instructions are supported):
  - index = pc[IDX_W:1];
  - tag = pc[XLEN-1:IDX_W+1].
- Entry contents: valid, tag, target, cnt.
- Lookup is combinational from the registered arrays; zero latency.
  - hit = valid[idx] && tag match.
  - target_o = hit ? target[idx] : 0.
- Prediction by mode:
  - MODE 0: hit = taken = 0 and target = 0. No table writes occur in this mode; statistics still count.
  - MODE 1: taken = hit.
  - MODE 2: taken = hit && cnt[CNT_W-1].
- Update on a rising edge when ex_valid_i && ex_is_branch_i && MODE != 0 && !flush_i:
  - Hit at ex_pc: cnt saturating-increments if taken and saturating-decrements if not taken, never wrapping past all-ones or 0. If taken, target <= ex_target_i; otherwise target is kept.
  - Miss and taken: allocate, overwriting any aliasing entry. valid = 1, tag and target written, cnt = 2^(CNT_W-1) (weakly taken).
  - Miss and not taken: no change.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents. No bypass.
- flush_i: all valid bits clear at the next edge. flush_i takes priority over an update in the same cycle. Targets and counters are untouched.
- Reset (asynchronous, active-high): all valid = 0, cnt = 2^(CNT_W-1)-1 (weakly not taken), targets 0, both statistics counters 0. All outputs read 0 during reset.
- Statistics:
  - stat_lookups_o += 1 per cycle with fetch_valid_i.
  - stat_mispred_o += 1 per cycle with ex_valid_i && ex_mispredict_i.
  - Both saturate at all-ones.
  - stat_clear_i zeroes both and takes priority over a same-cycle increment.
- Reset asserted mid-operation discards any pending update; the next lookup misses.

Decomposition:
- Shared package gets:
  - bp_mode_e enum: BP_OFF = 0, BP_HIT = 1, BP_BIMODAL = 2;
  - btb_entry_t packed struct template fields;
  - a saturating increment/decrement function.
- One natural sub-module: sat_counter (parametrised width, inc/dec/clear, saturating). It is reused for each direction counter and for the statistics counters.

Test Plan (XLEN=32, ENTRIES=16, CNT_W=2, MODE=2, STAT_W=4 unless stated):
- Reset, then fetch_pc 0x100 -> hit 0, taken 0, target 0x0.
- Taken update at pc 0x100, target 0x200 -> next cycle fetch 0x100 gives hit 1, taken 1, target 0x200. Two not-taken updates follow -> hit 1, taken 0, target still 0x200. Four taken updates -> cnt 3 with no wrap.
- Alias: after entry 0x100 exists, fetch 0x120 (same index 0, different tag) -> hit 0. Taken update at 0x120, target 0x300 -> fetch 0x100 misses, fetch 0x120 hits with target 0x300. A not-taken miss at 0x140 -> no allocation.
- Update to 0x100 and lookup of 0x100 in the same cycle -> lookup shows the old entry and the next cycle shows the new one. flush_i concurrent with a taken update -> every index misses afterward.
- 20 consecutive fetch_valid_i cycles -> stat_lookups_o = 15 (saturated). stat_clear_i together with fetch_valid_i -> 0.
- MODE=1: after the allocate at 0x100, three not-taken updates -> taken still 1. MODE=0: a taken update -> hit 0, while stat_mispred_o still counts.
